// File: rtl/fifo_uart_tx.sv
// 8N1 UART transmitter draining a show-ahead FIFO; all outputs registered.
// Define FIFO_UART_TX_PARITY_EN to compile in an even-parity bit (8E1 frames).
module fifo_uart_tx #(
  parameter logic [23:0] CLOCKS_PER_BAUD = 24'd104
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_en,
  input  logic       i_empty_n,
  input  logic [7:0] i_data,
  output logic       o_rd,
  output logic       o_uart_tx,
  output logic       o_busy
);

`ifdef FIFO_UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_STOP
  } state_t;
`endif

  localparam logic [23:0] RELOAD = CLOCKS_PER_BAUD - 24'd1;

  state_t      r_state, w_state;
  logic [23:0] r_cnt, w_cnt;
  logic [2:0]  r_idx, w_idx;
  logic [7:0]  r_shift, w_shift;
  logic        r_tx, w_tx;
  logic        r_rd, w_rd;
  logic        r_busy;
  logic        w_tick;
`ifdef FIFO_UART_TX_PARITY_EN
  logic        r_par, w_par;
`endif

  assign w_tick = (r_cnt == '0);

  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_idx   = r_idx;
    w_shift = r_shift;
    w_rd    = 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
    w_par   = r_par;
`endif
    if (r_state != S_IDLE) begin
      w_cnt = w_tick ? RELOAD : (r_cnt - 24'd1);
    end
    case (r_state)
      S_IDLE: begin
        if (i_en && i_empty_n) begin
          w_state = S_START;
          w_shift = i_data;
          w_cnt   = RELOAD;
          w_idx   = '0;
          w_rd    = 1'b1;
`ifdef FIFO_UART_TX_PARITY_EN
          w_par   = ^i_data;
`endif
        end
      end
      S_START: begin
        if (w_tick) w_state = S_DATA;
      end
      S_DATA: begin
        if (w_tick) begin
          w_shift = {1'b0, r_shift[7:1]};
          w_idx   = r_idx + 3'd1;
          if (r_idx == 3'd7) begin
`ifdef FIFO_UART_TX_PARITY_EN
            w_state = S_PARITY;
`else
            w_state = S_STOP;
`endif
          end
        end
      end
`ifdef FIFO_UART_TX_PARITY_EN
      S_PARITY: begin
        if (w_tick) w_state = S_STOP;
      end
`endif
      S_STOP: begin
        if (w_tick) w_state = S_IDLE;
      end
      default: w_state = S_IDLE;
    endcase

    // Line level is derived from the next state so o_uart_tx can be a flop.
    w_tx = 1'b1;
    case (w_state)
      S_START:  w_tx = 1'b0;
      S_DATA:   w_tx = w_shift[0];
`ifdef FIFO_UART_TX_PARITY_EN
      S_PARITY: w_tx = r_par;
`endif
      default:  w_tx = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
      r_rd    <= 1'b0;
      r_busy  <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_idx   <= w_idx;
      r_shift <= w_shift;
      r_tx    <= w_tx;
      r_rd    <= w_rd;
      r_busy  <= (w_state != S_IDLE);
`ifdef FIFO_UART_TX_PARITY_EN
      r_par   <= w_par;
`endif
    end
  end

  assign o_rd      = r_rd;
  assign o_uart_tx = r_tx;
  assign o_busy    = r_busy;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Self-checking bench for fifo_uart_tx: FIFO model, frame-level line monitor,
// vector table, corner-case sequences, random traffic and a 104-clock receiver.
`timescale 1ns/1ps
module tb_fifo_uart_tx;
  localparam int CPB = 4;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam int NB  = 11;
  localparam bit PAR = 1'b1;
`else
  localparam int NB  = 10;
  localparam bit PAR = 1'b0;
`endif
  localparam int FRAME = NB * CPB;
  localparam int CPB2  = 104;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b1;
  logic       en, empty_n, rd, tx, busy;
  logic [7:0] data;
  logic       en2, empty2, rd2, tx2, busy2;
  logic [7:0] data2;

  fifo_uart_tx #(.CLOCKS_PER_BAUD(24'd4)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_empty_n(empty_n),
    .i_data(data), .o_rd(rd), .o_uart_tx(tx), .o_busy(busy)
  );

  fifo_uart_tx dut104 (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en2), .i_empty_n(empty2),
    .i_data(data2), .o_rd(rd2), .o_uart_tx(tx2), .o_busy(busy2)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  // FIFO model: show-ahead queue, popped when the DUT strobes o_rd
  logic [7:0] q[$];
  function automatic void fifo_sync();
    empty_n = (q.size() != 0);
    data    = (q.size() != 0) ? q[0] : 8'($urandom);
  endfunction
  task automatic push(input logic [7:0] b);
    q.push_back(b);
    fifo_sync();
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         frames = 0;
  logic [7:0] dec_q[$];
  int         starts[$];
  logic [7:0] last_data;
  logic       last_stop, last_par;
  bit         pend = 1'b0;

  // Checks one whole frame cycle by cycle against the byte just popped.
  task automatic run_frame();
    logic [7:0]    b;
    logic [NB-1:0] s;
    logic          e;
    int            k;
    s = '0;
    if (q.size() == 0) begin
      chk("pop_nonempty", 0, 1);
      b = '0;
    end else begin
      b = q.pop_front();
    end
    fifo_sync();
    starts.push_back(cyc);
    for (int i = 0; i < FRAME; i++) begin
      if (i > 0) @(negedge clk);
      if (!rst_n) return;
      k = i / CPB;
      if (k == 0)               e = 1'b0;
      else if (k <= 8)          e = b[k-1];
      else if (PAR && k == 9)   e = ^b;
      else                      e = 1'b1;
      chk("frame_tx", tx, e);
      chk("frame_busy", busy, 1);
      chk("frame_rd", rd, (i == 0));
      if (i % CPB == CPB / 2) s[k] = tx;
    end
    frames++;
    dec_q.push_back(s[8:1]);
    last_data = s[8:1];
    last_stop = s[NB-1];
`ifdef FIFO_UART_TX_PARITY_EN
    last_par = s[9];
`else
    last_par = 1'b0;
`endif
  endtask

  // A frame must start exactly one cycle after an idle cycle sees en && not-empty.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pend = 1'b0;
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_rd", rd, 0);
      end else begin
        chk("rd_vs_model", rd, pend);
        if (pend) begin
          run_frame();
          pend = 1'b0;
        end else begin
          chk("idle_tx", tx, 1);
          chk("idle_busy", busy, 0);
          pend = en && empty_n;
        end
      end
    end
  end

  int rd2_cnt = 0;
  always @(negedge clk) if (rd2) rd2_cnt <= rd2_cnt + 1;

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_rd(input string name);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (rd) seen = 1'b1;
    end
    if (!seen) chk(name, 0, 1);
  endtask

  task automatic rx104(input logic [7:0] expb, input string name);
    logic [7:0] b;
    bit         seen;
    seen = 1'b0;
    b = '0;
    for (int c = 0; c < 5000 && !seen; c++) begin
      @(negedge clk);
      if (!tx2) seen = 1'b1;
    end
    if (!seen) begin
      chk({name, "_start_timeout"}, 0, 1);
      return;
    end
    chk({name, "_rd"}, rd2, 1);
    empty2 = 1'b0;
    repeat (CPB2 / 2) @(negedge clk);
    chk({name, "_startbit"}, tx2, 0);
    for (int k = 0; k < 8; k++) begin
      repeat (CPB2) @(negedge clk);
      b[k] = tx2;
    end
    if (PAR) begin
      repeat (CPB2) @(negedge clk);
      chk({name, "_par"}, tx2, ^expb);
    end
    repeat (CPB2) @(negedge clk);
    chk({name, "_stop"}, tx2, 1);
    chk({name, "_data"}, b, expb);
  endtask

  typedef struct {
    logic [7:0] data;
    bit         en;
    int         exp_frames;
    logic       exp_par;
  } vec_t;

  vec_t        vt[6];
  logic [7:0]  rq[$];
  logic [7:0]  rb;
  int          f0, s0, d0;
  logic [7:0]  b104[3];

  initial begin
    en = 1'b0; empty_n = 1'b0; data = '0;
    en2 = 1'b0; empty2 = 1'b0; data2 = '0;
    #2 rst_n = 1'b0;
    #2;
    chk("reset_tx", tx, 1);
    chk("reset_rd", rd, 0);
    chk("reset_busy", busy, 0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    settle(2);

    vt[0] = '{8'h55, 1'b1, 1, 1'b0};
    vt[1] = '{8'h07, 1'b1, 1, 1'b1};
    vt[2] = '{8'h03, 1'b1, 1, 1'b0};
    vt[3] = '{8'hC3, 1'b0, 0, 1'b0};
    vt[4] = '{8'h80, 1'b1, 1, 1'b1};
    vt[5] = '{8'hFF, 1'b1, 1, 1'b0};
    for (int i = 0; i < 6; i++) begin
      en = vt[i].en;
      f0 = frames;
      push(vt[i].data);
      settle(vt[i].en ? FRAME + 20 : 1000);
      chk("vec_frames", frames - f0, vt[i].exp_frames);
      if (vt[i].exp_frames != 0) begin
        chk("vec_data", last_data, vt[i].data);
        chk("vec_stop", last_stop, 1);
`ifdef FIFO_UART_TX_PARITY_EN
        chk("vec_parity", last_par, vt[i].exp_par);
`endif
      end else begin
        chk("vec_gated_queue", q.size(), 1);
        q.delete();
        fifo_sync();
      end
    end

    // back-to-back pair
    en = 1'b1;
    f0 = frames;
    s0 = starts.size();
    d0 = dec_q.size();
    push(8'hA5);
    push(8'h3C);
    settle(2 * FRAME + 30);
    chk("b2b_frames", frames - f0, 2);
    if (starts.size() >= s0 + 2 && dec_q.size() >= d0 + 2) begin
      chk("b2b_spacing", starts[s0+1] - starts[s0], FRAME + 1);
      chk("b2b_first", dec_q[d0], 8'hA5);
      chk("b2b_second", dec_q[d0+1], 8'h3C);
    end else begin
      chk("b2b_starts", starts.size(), s0 + 2);
    end

    // en dropped during data bit 3: current frame finishes, next byte waits
    f0 = frames;
    push(8'h3C);
    push(8'h55);
    wait_rd("gate_rd_timeout");
    repeat (17) @(posedge clk);
    #2 en = 1'b0;
    settle(FRAME + 100);
    chk("gate_frames", frames - f0, 1);
    chk("gate_queue", q.size(), 1);
    q.delete();
    fifo_sync();
    en = 1'b1;

    // reset during data bit 5
    f0 = frames;
    push(8'h5A);
    wait_rd("rst_rd_timeout");
    repeat (25) @(posedge clk);
    #2;
    chk("prerst_tx", tx, 0);
    rst_n = 1'b0;
    #1;
    chk("async_rst_tx", tx, 1);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_rd", rd, 0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    settle(200);
    chk("rst_no_resend", frames - f0, 0);
    chk("rst_queue", q.size(), 0);

    // random traffic with random enable toggling; FIFO order must be preserved
    f0 = frames;
    d0 = dec_q.size();
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 3))
        0, 1: if (q.size() < 4) begin
          rb = 8'($urandom);
          rq.push_back(rb);
          push(rb);
        end
        3: en = 1'($urandom_range(0, 1));
        default: ;
      endcase
      settle($urandom_range(1, 40));
    end
    en = 1'b1;
    settle(6 * (FRAME + 1) + 20);
    chk("rand_frames", frames - f0, rq.size());
    for (int i = 0; i < rq.size(); i++) begin
      if (d0 + i < dec_q.size()) chk("rand_data", dec_q[d0+i], rq[i]);
    end

    // default divider
    b104[0] = 8'h00;
    b104[1] = 8'hFF;
    b104[2] = 8'h5A;
    for (int i = 0; i < 3; i++) begin
      data2 = b104[i];
      empty2 = 1'b1;
      en2 = 1'b1;
      rx104(b104[i], "div104");
    end
    settle(CPB2 + 10);
    chk("div104_pops", rd2_cnt, 3);
    chk("div104_idle", tx2, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
